// File: rtl/csa_serial_add_seq.sv
// Word-serial wide adder: one WIDTH-bit carry-select slice is reused for WORDS
// cycles, LSW first, with the inter-word carry held in a register.

module full_adder_Nbit_csa #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // Lower half ripples from cin; upper half is precomputed for both carries.
  localparam int LO = (WIDTH > 1) ? WIDTH / 2 : 1;
  localparam int HI = WIDTH - LO;

  logic [LO:0] c_lo;

  assign c_lo[0] = cin;

  for (genvar i = 0; i < LO; i++) begin : g_lo
    assign sum[i]    = a[i] ^ b[i] ^ c_lo[i];
    assign c_lo[i+1] = (a[i] & b[i]) | (c_lo[i] & (a[i] ^ b[i]));
  end

  if (HI == 0) begin : g_no_hi
    assign cout = c_lo[LO];
  end else begin : g_hi
    logic [HI:0]   c0;
    logic [HI:0]   c1;
    logic [HI-1:0] s0;
    logic [HI-1:0] s1;

    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    for (genvar j = 0; j < HI; j++) begin : g_bit
      localparam int K = LO + j;
      assign s0[j]   = a[K] ^ b[K] ^ c0[j];
      assign c0[j+1] = (a[K] & b[K]) | (c0[j] & (a[K] ^ b[K]));
      assign s1[j]   = a[K] ^ b[K] ^ c1[j];
      assign c1[j+1] = (a[K] & b[K]) | (c1[j] & (a[K] ^ b[K]));
    end

    assign sum[WIDTH-1:LO] = c_lo[LO] ? s1 : s0;
    assign cout            = c_lo[LO] ? c1[HI] : c0[HI];
  end
endmodule

module csa_serial_add_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   busy
);
  localparam int TW = WIDTH * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [TW-1:0]  a_r;
  logic [TW-1:0]  b_r;
  logic           carry_r;
  logic [CW-1:0]  idx;
  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_sum;
  logic           slice_cout;
  logic           accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_ready && in_valid;

  assign slice_a = a_r[idx*WIDTH +: WIDTH];
  assign slice_b = b_r[idx*WIDTH +: WIDTH];

  full_adder_Nbit_csa #(.WIDTH(WIDTH)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum[idx*WIDTH +: WIDTH] <= slice_sum;
          carry_r                 <= slice_cout;
          if (idx == LAST) cout <= slice_cout;
          else             idx  <= idx + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_serial_add_seq.sv
// Directed and randomised checks of the word-serial adder in a 4x4 and a 1x8
// configuration, with hand-computed expected sums for the directed steps.

module tb_csa_serial_add_seq;
  logic clk;
  logic rst;

  logic        in_valid_4, in_ready_4, cin_4, out_valid_4, out_ready_4, cout_4, busy_4;
  logic [15:0] a_4, b_4, sum_4;
  logic        in_valid_8, in_ready_8, cin_8, out_valid_8, out_ready_8, cout_8, busy_8;
  logic [7:0]  a_8, b_8, sum_8;

  int checks   = 0;
  int failures = 0;

  csa_serial_add_seq #(.WIDTH(4), .WORDS(4)) dut_4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .cin(cin_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .sum(sum_4), .cout(cout_4), .busy(busy_4)
  );

  csa_serial_add_seq #(.WIDTH(8), .WORDS(1)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .a(a_8), .b(b_8), .cin(cin_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .sum(sum_8), .cout(cout_8), .busy(busy_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns {cout,sum} and RUN latency.
  task automatic op_4(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input bit watch_busy, output logic [16:0] res, output int lat);
    check("op4_in_ready", 32'(in_ready_4), 32'd1);
    in_valid_4 = 1'b1; a_4 = a; b_4 = b; cin_4 = c;
    @(negedge clk);
    in_valid_4 = 1'b0; a_4 = 16'h0; b_4 = 16'h0; cin_4 = 1'b0;
    lat = 0;
    while (out_valid_4 !== 1'b1 && lat < 40) begin
      if (watch_busy) begin
        check("run_busy", 32'(busy_4), 32'd1);
        check("run_in_ready", 32'(in_ready_4), 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    check("op4_out_valid", 32'(out_valid_4), 32'd1);
    res = {cout_4, sum_4};
  endtask

  task automatic release_4();
    out_ready_4 = 1'b1;
    @(negedge clk);
    out_ready_4 = 1'b0;
    check("rel4_out_valid", 32'(out_valid_4), 32'd0);
    check("rel4_in_ready", 32'(in_ready_4), 32'd1);
  endtask

  task automatic op_8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [8:0] res, output int lat);
    check("op8_in_ready", 32'(in_ready_8), 32'd1);
    in_valid_8 = 1'b1; a_8 = a; b_8 = b; cin_8 = c;
    @(negedge clk);
    in_valid_8 = 1'b0; a_8 = 8'h0; b_8 = 8'h0; cin_8 = 1'b0;
    lat = 0;
    while (out_valid_8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("op8_out_valid", 32'(out_valid_8), 32'd1);
    res = {cout_8, sum_8};
  endtask

  task automatic release_8();
    out_ready_8 = 1'b1;
    @(negedge clk);
    out_ready_8 = 1'b0;
    check("rel8_out_valid", 32'(out_valid_8), 32'd0);
    check("rel8_in_ready", 32'(in_ready_8), 32'd1);
  endtask

  initial begin
    logic [16:0] res4;
    logic [8:0]  res8;
    logic [15:0] held_sum, ra, rb;
    logic        held_cout, rc;
    logic [7:0]  ra8, rb8;
    int          lat;

    rst = 1'b1;
    in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; cin_4 = 1'b0; out_ready_4 = 1'b0;
    in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; out_ready_8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum_4), 32'h0);
    check("rst_cout", 32'(cout_4), 32'd0);
    check("rst_out_valid", 32'(out_valid_4), 32'd0);
    check("rst_busy", 32'(busy_4), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready_4), 32'd1);
    check("rst_in_ready_8", 32'(in_ready_8), 32'd1);
    @(negedge clk);

    // 1: basic add with latency of WORDS clock edges after the accept edge
    op_4(16'h1234, 16'h4321, 1'b1, 1'b0, res4, lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_result", 32'(res4), 32'h05556);
    release_4();

    // 2: carry ripples through all words
    op_4(16'hFFFF, 16'h0001, 1'b0, 1'b0, res4, lat);
    check("t2_result", 32'(res4), 32'h10000);
    release_4();

    // 3: top-word overflow plus carry-in, with busy/in_ready observed in RUN and DONE
    op_4(16'h8000, 16'h8000, 1'b1, 1'b1, res4, lat);
    check("t3_result", 32'(res4), 32'h10001);
    check("t3_done_busy", 32'(busy_4), 32'd1);
    check("t3_done_in_ready", 32'(in_ready_4), 32'd0);
    release_4();

    // 4: backpressure holds the result and blocks a new operand set
    op_4(16'hC000, 16'h4000, 1'b0, 1'b0, res4, lat);
    check("t4_result", 32'(res4), 32'h10000);
    held_sum = sum_4; held_cout = cout_4;
    in_valid_4 = 1'b1; a_4 = 16'hAAAA; b_4 = 16'h0000; cin_4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid_4), 32'd1);
      check("t4_hold_sum", 32'(sum_4), 32'(held_sum));
      check("t4_hold_cout", 32'(cout_4), 32'(held_cout));
      check("t4_hold_in_ready", 32'(in_ready_4), 32'd0);
    end
    out_ready_4 = 1'b1;
    @(negedge clk);
    out_ready_4 = 1'b0;
    check("t4_idle_valid", 32'(out_valid_4), 32'd0);
    check("t4_idle_in_ready", 32'(in_ready_4), 32'd1);
    @(negedge clk);
    in_valid_4 = 1'b0; a_4 = '0;
    check("t4_accepted", 32'(busy_4), 32'd1);
    lat = 0;
    while (out_valid_4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t4_aaaa_valid", 32'(out_valid_4), 32'd1);
    check("t4_aaaa_result", 32'({cout_4, sum_4}), 32'h0AAAA);
    release_4();

    // 5: reset at RUN idx=2 discards the partial result
    in_valid_4 = 1'b1; a_4 = 16'h1234; b_4 = 16'h4321; cin_4 = 1'b1;
    @(negedge clk);
    in_valid_4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_sum", 32'(sum_4), 32'h0);
    check("t5_cout", 32'(cout_4), 32'd0);
    check("t5_out_valid", 32'(out_valid_4), 32'd0);
    check("t5_busy", 32'(busy_4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_in_ready", 32'(in_ready_4), 32'd1);
    @(negedge clk);
    op_4(16'h0F0F, 16'h00F1, 1'b0, 1'b0, res4, lat);
    check("t5_result", 32'(res4), 32'h01000);
    release_4();

    // 6: random operations with idle gaps and consumer stalls
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      op_4(ra, rb, rc, 1'b0, res4, lat);
      check("rand4_result", 32'(res4), 32'({1'b0, ra} + {1'b0, rb} + 17'(rc)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_4();
    end

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      op_8(ra8, rb8, rc, res8, lat);
      check("rand8_latency", 32'(lat), 32'd1);
      check("rand8_result", 32'(res8), 32'({1'b0, ra8} + {1'b0, rb8} + 9'(rc)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_8();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
